// File: rtl/jelly_fixed_quotient_saturator_if.sv
// Stream bundle around the quotient saturator: divider-side s_* in, output-side m_* out.
// slave is the saturator's own view; master is the view of whatever sits on both ends.
interface jelly_fixed_quotient_saturator_if #(
   parameter int USER_BITS = 1,
   parameter int S_W       = 16,
   parameter int M_W       = 10
);
   logic [USER_BITS-1:0] s_user;
   logic [S_W-1:0]       s_quotient;
   logic                 s_valid;
   logic                 s_ready;
   logic [USER_BITS-1:0] m_user;
   logic [M_W-1:0]       m_data;
   logic                 m_overflow;
   logic                 m_valid;
   logic                 m_ready;

   modport slave (
      input  s_user, s_quotient, s_valid, m_ready,
      output s_ready, m_user, m_data, m_overflow, m_valid
   );

   modport master (
      output s_user, s_quotient, s_valid, m_ready,
      input  s_ready, m_user, m_data, m_overflow, m_valid
   );
endinterface

// File: rtl/jelly_fixed_quotient_saturator.sv
// Rescales a signed fixed-point quotient to the output Q format, saturates it, and
// forwards it through a registered 2-entry skid buffer with a saturation event counter.
module jelly_fixed_quotient_saturator #(
   parameter int USER_WIDTH   = 0,
   parameter int S_INT_WIDTH  = 12,
   parameter int S_FRAC_WIDTH = 4,
   parameter int M_INT_WIDTH  = 8,
   parameter int M_FRAC_WIDTH = 2,
   parameter int ROUNDING     = 1,
   parameter int COUNT_WIDTH  = 16
) (
   input  logic                   reset,
   input  logic                   clk,
   input  logic                   cke,
   jelly_fixed_quotient_saturator_if.slave bus,
   input  logic                   clear_count,
   output logic [COUNT_WIDTH-1:0] overflow_count
);
   localparam int USER_BITS = (USER_WIDTH > 0) ? USER_WIDTH : 1;
   localparam int S_W       = S_INT_WIDTH + S_FRAC_WIDTH;
   localparam int M_W       = M_INT_WIDTH + M_FRAC_WIDTH;
   localparam int D         = S_FRAC_WIDTH - M_FRAC_WIDTH;
   localparam int T_W       = (D > 0) ? S_W + 1 : S_W - D + 1;
   // One spare bit so the clamp compare never sees a wrapped value.
   localparam int W         = ((T_W > M_W) ? T_W : M_W) + 1;

   localparam logic signed [W-1:0] SAT_MAX = {{(W - M_W + 1){1'b0}}, {(M_W - 1){1'b1}}};
   localparam logic signed [W-1:0] SAT_MIN = {{(W - M_W + 1){1'b1}}, {(M_W - 1){1'b0}}};

   logic signed [T_W-1:0] t;
   logic signed [W-1:0]   tw;
   logic [M_W-1:0]        new_data;
   logic                  new_ovf;

   if (D > 0) begin : g_shr
      localparam logic [S_W:0] RND = (ROUNDING != 0) ? ((S_W + 1)'(1) << (D - 1)) : '0;
      logic signed [S_W:0] sum;
      assign sum = $signed({bus.s_quotient[S_W-1], bus.s_quotient}) + $signed(RND);
      assign t   = sum >>> D;
   end else begin : g_shl
      assign t = $signed({{(T_W - S_W){bus.s_quotient[S_W-1]}}, bus.s_quotient}) <<< (-D);
   end

   always_comb begin
      tw       = {{(W - T_W){t[T_W-1]}}, t};
      new_ovf  = 1'b0;
      new_data = tw[M_W-1:0];
      if (tw > SAT_MAX) begin
         new_ovf  = 1'b1;
         new_data = SAT_MAX[M_W-1:0];
      end else if (tw < SAT_MIN) begin
         new_ovf  = 1'b1;
         new_data = SAT_MIN[M_W-1:0];
      end
   end

   logic                   main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
   logic [M_W-1:0]         main_data_q, main_data_d, skid_data_q, skid_data_d;
   logic                   main_ovf_q, main_ovf_d, skid_ovf_q, skid_ovf_d;
   logic [USER_BITS-1:0]   main_user_q, main_user_d, skid_user_q, skid_user_d;
   logic                   s_ready_q, s_ready_d;
   logic [COUNT_WIDTH-1:0] count_q, count_d;
   logic                   accept, emit, inc;

   always_comb begin
      main_valid_d = main_valid_q;
      main_data_d  = main_data_q;
      main_ovf_d   = main_ovf_q;
      main_user_d  = main_user_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      skid_ovf_d   = skid_ovf_q;
      skid_user_d  = skid_user_q;
      count_d      = count_q;

      accept = bus.s_valid & s_ready_q;
      emit   = main_valid_q & bus.m_ready;
      inc    = accept & new_ovf;

      // s_ready_q is low whenever skid holds data, so accept never coincides with a skid drain.
      if (emit) begin
         if (skid_valid_q) begin
            main_data_d  = skid_data_q;
            main_ovf_d   = skid_ovf_q;
            main_user_d  = skid_user_q;
            skid_valid_d = 1'b0;
         end else if (accept) begin
            main_data_d = new_data;
            main_ovf_d  = new_ovf;
            main_user_d = bus.s_user;
         end else begin
            main_valid_d = 1'b0;
         end
      end else if (accept) begin
         if (main_valid_q) begin
            skid_valid_d = 1'b1;
            skid_data_d  = new_data;
            skid_ovf_d   = new_ovf;
            skid_user_d  = bus.s_user;
         end else begin
            main_valid_d = 1'b1;
            main_data_d  = new_data;
            main_ovf_d   = new_ovf;
            main_user_d  = bus.s_user;
         end
      end
      s_ready_d = ~skid_valid_d;

      if (clear_count) begin
         count_d = inc ? COUNT_WIDTH'(1) : '0;
      end else if (inc && (count_q != '1)) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         main_valid_q <= 1'b0;
         main_data_q  <= '0;
         main_ovf_q   <= 1'b0;
         main_user_q  <= '0;
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
         skid_ovf_q   <= 1'b0;
         skid_user_q  <= '0;
         s_ready_q    <= 1'b1;
         count_q      <= '0;
      end else if (cke) begin
         main_valid_q <= main_valid_d;
         main_data_q  <= main_data_d;
         main_ovf_q   <= main_ovf_d;
         main_user_q  <= main_user_d;
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
         skid_ovf_q   <= skid_ovf_d;
         skid_user_q  <= skid_user_d;
         s_ready_q    <= s_ready_d;
         count_q      <= count_d;
      end
   end

   assign bus.s_ready     = s_ready_q;
   assign bus.m_valid     = main_valid_q;
   assign bus.m_data      = main_data_q;
   assign bus.m_overflow  = main_ovf_q;
   assign bus.m_user      = main_user_q;
   assign overflow_count  = count_q;
endmodule

// File: tb/tb_jelly_fixed_quotient_saturator.sv
// Drives a rounding instance and a truncating, 4-bit-counter instance with identical streams
// and compares both against an arithmetic reference model and a FIFO scoreboard.
module tb_jelly_fixed_quotient_saturator;
   localparam int CW_T = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic cke = 1'b1;
   logic clear_count = 1'b0;
   logic [15:0]     count_r;
   logic [CW_T-1:0] count_t;

   always #5 clk = ~clk;

   jelly_fixed_quotient_saturator_if #(.USER_BITS(1), .S_W(16), .M_W(10)) bus_r ();
   jelly_fixed_quotient_saturator_if #(.USER_BITS(1), .S_W(16), .M_W(10)) bus_t ();

   assign bus_t.s_user     = bus_r.s_user;
   assign bus_t.s_quotient = bus_r.s_quotient;
   assign bus_t.s_valid    = bus_r.s_valid;
   assign bus_t.m_ready    = bus_r.m_ready;

   jelly_fixed_quotient_saturator dut_r (
      .reset          (reset),
      .clk            (clk),
      .cke            (cke),
      .bus            (bus_r),
      .clear_count    (clear_count),
      .overflow_count (count_r)
   );

   jelly_fixed_quotient_saturator #(.ROUNDING(0), .COUNT_WIDTH(CW_T)) dut_t (
      .reset          (reset),
      .clk            (clk),
      .cke            (cke),
      .bus            (bus_t),
      .clear_count    (clear_count),
      .overflow_count (count_t)
   );

   typedef struct {
      logic u;
      int   dr;
      bit   ovr;
      int   dt;
      bit   ovt;
   } exp_t;

   exp_t sq[$];
   int   cnt_r = 0;
   int   cnt_t = 0;
   int   checks = 0;
   int   failures = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                  tag, $signed(obs), obs, $signed(exp), exp, $time);
      end
   endtask

   // Q12.4 -> Q8.2: add half an output LSB if rounding, floor-divide by 4, clamp to 10 bits.
   function automatic void quant(input logic [15:0] q, input bit rnd,
                                 output int data, output bit ovf);
      longint v;
      v = longint'($signed(q));
      if (rnd) v = v + 2;
      v = v >>> 2;
      ovf = 1'b1;
      if (v > 511) data = 511;
      else if (v < -512) data = -512;
      else begin
         data = int'(v);
         ovf  = 1'b0;
      end
   endfunction

   task automatic step(input bit sv, input logic [15:0] q, input logic u, input bit mr,
                       input bit ck, input bit clr, input bit rst);
      exp_t e;
      bit   acc, emt;
      @(negedge clk);
      check("s_ready_r", 32'(bus_r.s_ready), 32'(sq.size() < 2));
      check("m_valid_r", 32'(bus_r.m_valid), 32'(sq.size() > 0));
      check("m_valid_t", 32'(bus_t.m_valid), 32'(sq.size() > 0));
      check("count_r", 32'(count_r), cnt_r);
      check("count_t", 32'(count_t), cnt_t);
      if (sq.size() > 0) begin
         check("data_r", int'($signed(bus_r.m_data)), sq[0].dr);
         check("ovf_r", 32'(bus_r.m_overflow), 32'(sq[0].ovr));
         check("user_r", 32'(bus_r.m_user), 32'(sq[0].u));
         check("data_t", int'($signed(bus_t.m_data)), sq[0].dt);
         check("ovf_t", 32'(bus_t.m_overflow), 32'(sq[0].ovt));
      end
      bus_r.s_valid    = sv;
      bus_r.s_quotient = q;
      bus_r.s_user     = u;
      bus_r.m_ready    = mr;
      cke              = ck;
      clear_count      = clr;
      reset            = rst;
      if (rst) begin
         sq.delete();
         cnt_r = 0;
         cnt_t = 0;
      end else if (ck) begin
         acc = sv && (sq.size() < 2);
         emt = mr && (sq.size() > 0);
         e.u = u;
         quant(q, 1'b1, e.dr, e.ovr);
         quant(q, 1'b0, e.dt, e.ovt);
         if (emt) void'(sq.pop_front());
         if (acc) sq.push_back(e);
         if (clr) begin
            cnt_r = (acc && e.ovr) ? 1 : 0;
            cnt_t = (acc && e.ovt) ? 1 : 0;
         end else begin
            if (acc && e.ovr && cnt_r < 65535) cnt_r++;
            if (acc && e.ovt && cnt_t < 15) cnt_t++;
         end
      end
   endtask

   task automatic idle();
      step(1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic send(input logic [15:0] q, input logic u, input bit mr);
      step(1'b1, q, u, mr, 1'b1, 1'b0, 1'b0);
   endtask

   function automatic logic [15:0] rand_q();
      int sel;
      sel = int'($urandom_range(0, 3));
      case (sel)
         0:       return 16'($urandom);
         1:       return 16'(2044 + int'($urandom_range(0, 8)) - 4);
         2:       return 16'(-2050 + int'($urandom_range(0, 8)) - 4);
         default: return 16'(int'($urandom_range(0, 4200)) - 2100);
      endcase
   endfunction

   initial begin
      bus_r.s_valid    = 1'b0;
      bus_r.s_quotient = '0;
      bus_r.s_user     = 1'b0;
      bus_r.m_ready    = 1'b0;

      step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      idle();
      check("rst_data", 32'(bus_r.m_data), 0);
      check("rst_ovf", 32'(bus_r.m_overflow), 0);
      check("rst_user", 32'(bus_r.m_user), 0);
      check("rst_ready", 32'(bus_r.s_ready), 1);

      // 1.375 -> 1.5 rounded
      send(16'd22, 1'b1, 1'b1);
      idle();
      check("t1_data", int'($signed(bus_r.m_data)), 6);
      check("t1_ovf", 32'(bus_r.m_overflow), 0);
      check("t1_user", 32'(bus_r.m_user), 1);
      check("t1_count", 32'(count_r), 0);

      // tie at -1.625
      send(-16'sd26, 1'b0, 1'b1);
      idle();
      check("t2_round", int'($signed(bus_r.m_data)), -6);
      check("t2_trunc", int'($signed(bus_t.m_data)), -7);

      send(16'h7FFF, 1'b0, 1'b1);
      idle();
      check("t3_max", int'($signed(bus_r.m_data)), 511);
      check("t3_max_ovf", 32'(bus_r.m_overflow), 1);
      send(16'h8000, 1'b0, 1'b1);
      idle();
      check("t3_min", int'($signed(bus_r.m_data)), -512);
      check("t3_min_ovf", 32'(bus_r.m_overflow), 1);
      check("t3_count", 32'(count_r), 2);

      send(16'd2046, 1'b0, 1'b1);
      idle();
      check("t4_carry", int'($signed(bus_r.m_data)), 511);
      check("t4_carry_ovf", 32'(bus_r.m_overflow), 1);
      check("t4_trunc_ovf", 32'(bus_t.m_overflow), 0);
      send(16'd2044, 1'b0, 1'b1);
      idle();
      check("t4_edge", int'($signed(bus_r.m_data)), 511);
      check("t4_edge_ovf", 32'(bus_r.m_overflow), 0);

      // Backpressure: A main, B skid, C stalled
      send(16'd4, 1'b0, 1'b0);
      send(16'd8, 1'b1, 1'b0);
      send(16'd12, 1'b0, 1'b0);
      check("t5_stall", 32'(bus_r.s_ready), 0);
      check("t5_head", int'($signed(bus_r.m_data)), 1);
      send(16'd12, 1'b0, 1'b1);
      send(16'd12, 1'b0, 1'b1);
      idle();
      idle();
      check("t5_ready", 32'(bus_r.s_ready), 1);
      check("t5_drained", 32'(bus_r.m_valid), 0);

      // Freeze with both slots full, then reset
      send(16'd20, 1'b0, 1'b0);
      send(16'd24, 1'b0, 1'b0);
      step(1'b1, 16'd28, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      step(1'b1, 16'd28, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      check("t6_frz_data", int'($signed(bus_r.m_data)), 5);
      check("t6_frz_ready", 32'(bus_r.s_ready), 0);
      check("t6_frz_valid", 32'(bus_r.m_valid), 1);
      step(1'b1, 16'd28, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      idle();
      check("t6_rst_valid", 32'(bus_r.m_valid), 0);
      check("t6_rst_ready", 32'(bus_r.s_ready), 1);

      // Counter saturation on the 4-bit instance
      for (int i = 0; i < 16; i++) send(16'h7FFF, 1'b0, 1'b1);
      idle();
      check("t6_sat", 32'(count_t), 15);
      check("t6_cnt16", 32'(count_r), 16);
      send(16'h7FFF, 1'b0, 1'b1);
      idle();
      check("t6_sat_hold", 32'(count_t), 15);
      step(1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      idle();
      check("t6_clr_inc", 32'(count_t), 1);
      check("t6_clr_inc_r", 32'(count_r), 1);
      step(1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      idle();
      check("t6_clr", 32'(count_t), 0);

      for (int i = 0; i < 2500; i++) begin
         step(($urandom_range(0, 3) != 0), rand_q(), 1'($urandom), ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 7) != 0), ($urandom_range(0, 63) == 0),
              ($urandom_range(0, 499) == 0));
      end
      idle();
      idle();
      idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
